frame_capture_ctrl: RTL and testbench

Sequences capture of one sensor frame into the shared single-port RGB frame store. It consumes the frame_valid/line_valid/rgb_data pixel stream and generates raster write addresses. It arbitrates the same memory port between the capture writer and a downstream read requester, such as blob labelling or a host dump. It flags short and overlong frames and pulses a completion strobe that downstream stages use to start processing.

---
 rtl/frame_capture_ctrl_pkg.sv | 28 ++
 rtl/frame_capture_ctrl_arb.sv | 55 +++++
 rtl/frame_capture_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_frame_capture_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_capture_ctrl_pkg.sv
// Shared definitions for the frame capture controller: default widths,
// the capture FSM state encoding and {R,G,B} field slicing macros.
// Optional feature macro used by the top: FCAP_STATS_EN.
`ifndef FRAME_CAPTURE_CTRL_PKG_SV
`define FRAME_CAPTURE_CTRL_PKG_SV

// Slice one colour channel out of a packed {R,G,B} pixel of channel width w.
`define FCAP_R(pix, w) pix[3*(w)-1 -: (w)]
`define FCAP_G(pix, w) pix[2*(w)-1 -: (w)]
`define FCAP_B(pix, w) pix[(w)-1 -: (w)]

package frame_capture_ctrl_pkg;

  localparam int unsigned FCAP_PIXSIZE  = 8;
  localparam int unsigned FCAP_ADDR_W   = 19;
  localparam int unsigned FCAP_MAX_COLS = 640;
  localparam int unsigned FCAP_MAX_ROWS = 480;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } fcap_state_t;

endpackage

`endif

// File: rtl/frame_capture_ctrl_arb.sv
// Single-port frame-store arbiter: capture writes always win, a read
// request is granted on any cycle without a write, and the read result
// is returned registered one cycle after the grant.
module frame_store_arb
  import frame_capture_ctrl_pkg::*;
#(
  parameter int unsigned PIXSIZE = FCAP_PIXSIZE,
  parameter int unsigned ADDR_W  = FCAP_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [3*PIXSIZE-1:0]   wr_data,
  input  logic                   rd_req,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_we,
  output logic                   mem_re,
  output logic [3*PIXSIZE-1:0]   mem_wdata,
  input  logic [3*PIXSIZE-1:0]   mem_rdata,
  output logic                   rd_gnt,
  output logic                   rd_valid,
  output logic [3*PIXSIZE-1:0]   rd_data
);

  // Port mux: write has absolute priority, otherwise the granted read.
  always_comb begin
    mem_we    = wr_en;
    rd_gnt    = rd_req && !wr_en;
    mem_re    = rd_gnt;
    mem_wdata = wr_en ? wr_data : '0;
    mem_addr  = '0;
    if (wr_en) begin
      mem_addr = wr_addr;
    end else if (rd_gnt) begin
      mem_addr = rd_addr;
    end
  end

  // Read return: mem_rdata is sampled at the edge closing the grant cycle,
  // so rd_valid and rd_data appear together on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_gnt;
      if (rd_gnt) begin
        rd_data <= mem_rdata;
      end
    end
  end

endmodule

// File: rtl/frame_capture_ctrl.sv
// Frame capture controller: arms on request, captures the next complete
// sensor frame into the shared frame store in raster order, flags short
// and overlong frames and pulses frame_done at the end of capture.
// Optional feature macro: FCAP_STATS_EN (per-channel pixel sums).
module frame_capture_ctrl
  import frame_capture_ctrl_pkg::*;
#(
  parameter int unsigned PIXSIZE  = FCAP_PIXSIZE,
  parameter int unsigned ADDR_W   = FCAP_ADDR_W,
  parameter int unsigned MAX_COLS = FCAP_MAX_COLS,
  parameter int unsigned MAX_ROWS = FCAP_MAX_ROWS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm,
  input  logic [15:0]            cfg_cols,
  input  logic [15:0]            cfg_rows,
  input  logic                   frame_valid,
  input  logic                   line_valid,
  input  logic [3*PIXSIZE-1:0]   rgb_data,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_we,
  output logic                   mem_re,
  output logic [3*PIXSIZE-1:0]   mem_wdata,
  input  logic [3*PIXSIZE-1:0]   mem_rdata,
  input  logic                   rd_req,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic                   rd_gnt,
  output logic                   rd_valid,
  output logic [3*PIXSIZE-1:0]   rd_data,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err_short,
  output logic                   err_over,
  output logic [ADDR_W-1:0]      pix_count
`ifdef FCAP_STATS_EN
  ,
  output logic [PIXSIZE+ADDR_W-1:0] sum_r,
  output logic [PIXSIZE+ADDR_W-1:0] sum_g,
  output logic [PIXSIZE+ADDR_W-1:0] sum_b
`endif
);

  localparam logic [15:0] MAX_C = 16'(MAX_COLS);
  localparam logic [15:0] MAX_R = 16'(MAX_ROWS);

  fcap_state_t         state_q;
  logic                wait_fall_q;
  logic [15:0]         cols_q;
  logic [15:0]         rows_q;
  logic [ADDR_W-1:0]   total_q;
  logic [15:0]         col_q;
  logic [15:0]         row_q;

  logic [15:0]         cols_eff;
  logic [15:0]         rows_eff;
  logic [ADDR_W-1:0]   area_eff;
  logic                full;
  logic                wr_en;

  // Clamp the requested geometry and form the frame area presented at arm.
  always_comb begin
    cols_eff = (cfg_cols == '0 || cfg_cols > MAX_C) ? MAX_C : cfg_cols;
    rows_eff = (cfg_rows == '0 || cfg_rows > MAX_R) ? MAX_R : cfg_rows;
    area_eff = ADDR_W'({16'd0, cols_eff} * {16'd0, rows_eff});
  end

  // Write qualification; the raster has wrapped past the last row exactly
  // when pix_count has reached cols*rows, so the row counter marks "full".
  always_comb begin
    full  = (row_q == rows_q);
    wr_en = (state_q == CAPTURE) && frame_valid && line_valid && !full;
  end

  // Capture FSM with raster counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_fall_q <= 1'b0;
      cols_q      <= '0;
      rows_q      <= '0;
      total_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      pix_count   <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      err_short   <= 1'b0;
      err_over    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arm) begin
            cols_q      <= cols_eff;
            rows_q      <= rows_eff;
            total_q     <= area_eff;
            col_q       <= '0;
            row_q       <= '0;
            pix_count   <= '0;
            err_short   <= 1'b0;
            err_over    <= 1'b0;
            wait_fall_q <= frame_valid;
            busy        <= 1'b1;
            state_q     <= ARMED;
          end
        end
        ARMED: begin
          if (wait_fall_q) begin
            if (!frame_valid) begin
              wait_fall_q <= 1'b0;
            end
          end else if (frame_valid) begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (!frame_valid) begin
            state_q    <= DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            if (pix_count < total_q) begin
              err_short <= 1'b1;
            end
          end else if (line_valid) begin
            if (full) begin
              err_over <= 1'b1;
            end else begin
              pix_count <= pix_count + ADDR_W'(1);
              if (col_q == cols_q - 16'd1) begin
                col_q <= '0;
                row_q <= row_q + 16'd1;
              end else begin
                col_q <= col_q + 16'd1;
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FCAP_STATS_EN
  localparam int unsigned SUM_W = PIXSIZE + ADDR_W;

  // Per-channel sums of every written pixel, cleared by an accepted arm.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r <= '0;
      sum_g <= '0;
      sum_b <= '0;
    end else if (state_q == IDLE && arm) begin
      sum_r <= '0;
      sum_g <= '0;
      sum_b <= '0;
    end else if (wr_en) begin
      sum_r <= sum_r + SUM_W'(`FCAP_R(rgb_data, PIXSIZE));
      sum_g <= sum_g + SUM_W'(`FCAP_G(rgb_data, PIXSIZE));
      sum_b <= sum_b + SUM_W'(`FCAP_B(rgb_data, PIXSIZE));
    end
  end
`endif

  frame_store_arb #(
    .PIXSIZE (PIXSIZE),
    .ADDR_W  (ADDR_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (pix_count),
    .wr_data   (rgb_data),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data)
  );

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Self-checking bench for frame_capture_ctrl: a driver issues frames and
// reads while pushing expected writes/reads/frame results into queues; a
// negedge monitor pops and compares whenever the DUT presents an output.
module tb_frame_capture_ctrl;

  localparam int unsigned AW = 19;
  localparam int unsigned DW = 24;

  logic           clk = 1'b0;
  logic           rst;
  logic           arm;
  logic [15:0]    cfg_cols, cfg_rows;
  logic           frame_valid, line_valid;
  logic [DW-1:0]  rgb_data;
  logic [AW-1:0]  mem_addr;
  logic           mem_we, mem_re;
  logic [DW-1:0]  mem_wdata, mem_rdata;
  logic           rd_req;
  logic [AW-1:0]  rd_addr;
  logic           rd_gnt, rd_valid;
  logic [DW-1:0]  rd_data;
  logic           busy, frame_done, err_short, err_over;
  logic [AW-1:0]  pix_count;
`ifdef FCAP_STATS_EN
  logic [8+AW-1:0] sum_r, sum_g, sum_b;
`endif

  always #5 clk = ~clk;

  frame_capture_ctrl #(.PIXSIZE(8), .ADDR_W(AW), .MAX_COLS(640), .MAX_ROWS(480)) dut (
    .clk(clk), .rst(rst), .arm(arm), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .frame_valid(frame_valid), .line_valid(line_valid), .rgb_data(rgb_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .frame_done(frame_done),
    .err_short(err_short), .err_over(err_over), .pix_count(pix_count)
`ifdef FCAP_STATS_EN
    , .sum_r(sum_r), .sum_g(sum_g), .sum_b(sum_b)
`endif
  );

  // Frame store model: asynchronous read, write on the clock edge.
  logic [DW-1:0] mem     [0:4095];
  logic [DW-1:0] ref_img [0:4095];
  assign mem_rdata = mem[mem_addr[11:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { int pix; bit es; bit eo; longint sr; longint sg; longint sb; } fr_t;
  wr_t           exp_wr[$];
  logic [DW-1:0] exp_rd[$];
  fr_t           exp_fr[$];
  logic [DW-1:0] frame_px [0:63];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void fail_now(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endfunction

  // Monitor: compares every write, read return and frame completion.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        if (exp_wr.size() == 0) fail_now("unexpected_write");
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("wr_addr", mem_addr, w.addr);
          chk("wr_data", mem_wdata, w.data);
        end
      end
      if (rd_req) begin
        chk("rd_gnt_rule", rd_gnt, !mem_we);
        chk("mem_re_eq_gnt", mem_re, rd_gnt);
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0) fail_now("unexpected_rd_valid");
        else chk("rd_data", rd_data, exp_rd.pop_front());
      end
      if (frame_done) begin
        if (exp_fr.size() == 0) fail_now("unexpected_frame_done");
        else begin
          fr_t f;
          f = exp_fr.pop_front();
          chk("pix_count", pix_count, f.pix);
          chk("err_short", err_short, f.es);
          chk("err_over", err_over, f.eo);
          chk("busy_at_done", busy, 0);
`ifdef FCAP_STATS_EN
          chk("sum_r", sum_r, f.sr);
          chk("sum_g", sum_g, f.sg);
          chk("sum_b", sum_b, f.sb);
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff(int v, int mx);
    return (v == 0 || v > mx) ? mx : v;
  endfunction

  task automatic do_arm(input int c, input int r);
    arm = 1'b1; cfg_cols = 16'(c); cfg_rows = 16'(r);
    tick();
    arm = 1'b0;
  endtask

  task automatic check_all_zero(string tag);
    @(negedge clk);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_re"}, mem_re, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_errs"}, {err_short, err_over}, 0);
    chk({tag, "_pix_count"}, pix_count, 0);
    @(posedge clk); #1;
  endtask

  task automatic fill_px(input bit rnd, input logic [DW-1:0] val);
    for (int i = 0; i < 64; i++) frame_px[i] = rnd ? DW'($urandom) : val;
  endtask

  // Drive a frame of n pixels in lines of line_len; when cap is set the
  // model expects the first min(n,total) pixels at raster addresses.
  task automatic send_frame(input int n, input int line_len, input int total,
                            input bit cap, input int gap_mode);
    fr_t f;
    int  g;
    f = '{pix: 0, es: 0, eo: 0, sr: 0, sg: 0, sb: 0};
    frame_valid = 1'b1; line_valid = 1'b0;
    @(negedge clk);
    if (cap) chk("busy_armed", busy, 1);
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      g = 0;
      if (k > 0 && k % line_len == 0) g = 2;
      if (gap_mode == 1 && k > 0 && k % 5 == 0) g += 16;
      if (gap_mode == 2 && $urandom_range(0, 3) == 0) g += $urandom_range(1, 4);
      line_valid = 1'b0;
      repeat (g) tick();
      if (cap && k < total) begin
        exp_wr.push_back('{addr: AW'(k), data: frame_px[k]});
        ref_img[k] = frame_px[k];
        f.pix++;
        f.sr += frame_px[k][23:16];
        f.sg += frame_px[k][15:8];
        f.sb += frame_px[k][7:0];
      end
      line_valid = 1'b1; rgb_data = frame_px[k];
      tick();
    end
    line_valid = 1'b0; rgb_data = '0;
    tick();
    f.es = (n < total);
    f.eo = (n > total);
    if (cap) exp_fr.push_back(f);
    frame_valid = 1'b0;
    @(negedge clk);
    if (cap) chk("frame_done_early", frame_done, 0);
    @(posedge clk); #1;
    @(negedge clk);
    if (cap) chk("frame_done_latency", frame_done, 1);
    @(posedge clk); #1;
    tick();
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    bit got;
    got = 1'b0;
    rd_req = 1'b1; rd_addr = a;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clk);
      if (rd_gnt) begin
        exp_rd.push_back(ref_img[a[11:0]]);
        got = 1'b1;
      end
      @(posedge clk); #1;
    end
    rd_req = 1'b0;
    if (!got) fail_now("rd_grant_timeout");
  endtask

  task automatic reader(input int cnt, input int lo, input int hi);
    for (int j = 0; j < cnt; j++) begin
      do_read(AW'($urandom_range(lo, hi)));
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = DW'(i * 7919 + 3);
      ref_img[i] = DW'(i * 7919 + 3);
    end
    rst = 1'b1; arm = 1'b0; cfg_cols = '0; cfg_rows = '0;
    frame_valid = 1'b0; line_valid = 1'b0; rgb_data = '0;
    rd_req = 1'b0; rd_addr = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // 8x4 gap-free frame with a concurrent reader, then read-back.
    fill_px(1'b1, '0);
    do_arm(8, 4);
    do_arm(2, 2);   // ignored while ARMED
    fork
      send_frame(32, 8, 32, 1'b1, 0);
      reader(4, 1024, 4095);
    join
    reader(6, 0, 31);

    // Same pixels with 16-cycle line_valid gaps every 5 pixels.
    do_arm(8, 4);
    send_frame(32, 8, 32, 1'b1, 1);
    reader(4, 0, 31);

    // Arm while a frame is in progress: that frame is skipped.
    frame_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      line_valid = 1'b1; rgb_data = DW'($urandom);
      if (k == 2) begin arm = 1'b1; cfg_cols = 16'd8; cfg_rows = 16'd4; end
      tick();
      arm = 1'b0;
    end
    line_valid = 1'b0; frame_valid = 1'b0;
    repeat (3) tick();
    fill_px(1'b1, '0);
    send_frame(32, 8, 32, 1'b1, 0);

    // Short and overlong frames.
    fill_px(1'b1, '0);
    do_arm(8, 4);
    send_frame(30, 8, 32, 1'b1, 0);
    fill_px(1'b1, '0);
    do_arm(8, 4);
    send_frame(40, 8, 32, 1'b1, 0);

    // Clamped configurations (0 and above the maximum).
    fill_px(1'b1, '0);
    do_arm(0, 1);
    send_frame(10, 10, eff(0, 640) * eff(1, 480), 1'b1, 0);
    fill_px(1'b1, '0);
    do_arm(1, 900);
    send_frame(6, 1, eff(1, 640) * eff(900, 480), 1'b1, 0);

    // Randomised geometry, length, gaps and concurrent reads.
    for (int it = 0; it < 8; it++) begin
      int c, r, tot, n;
      c = $urandom_range(1, 8);
      r = $urandom_range(1, 4);
      tot = c * r;
      n = $urandom_range((tot > 3) ? tot - 3 : 1, tot + 3);
      fill_px(1'b1, '0);
      do_arm(c, r);
      fork
        send_frame(n, c, tot, 1'b1, 2);
        reader(3, 1024, 4095);
      join
      reader(2, 0, tot - 1);
    end

    // Reset mid-line, then a clean capture.
    fill_px(1'b1, '0);
    do_arm(8, 4);
    frame_valid = 1'b1; tick();
    for (int k = 0; k < 5; k++) begin
      exp_wr.push_back('{addr: AW'(k), data: frame_px[k]});
      ref_img[k] = frame_px[k];
      line_valid = 1'b1; rgb_data = frame_px[k];
      tick();
    end
    rst = 1'b1; line_valid = 1'b0;
    tick();
    rst = 1'b0; line_valid = 1'b1; rgb_data = DW'($urandom);
    check_all_zero("after_rst");
    line_valid = 1'b0; frame_valid = 1'b0;
    repeat (2) tick();
    fill_px(1'b1, '0);
    do_arm(8, 4);
    send_frame(32, 8, 32, 1'b1, 2);

    // Uniform 4x2 frame: sums are 8x each channel when stats are enabled.
    fill_px(1'b0, 24'h102030);
    do_arm(4, 2);
    send_frame(8, 4, 8, 1'b1, 0);
`ifdef FCAP_STATS_EN
    chk("sum_r_uniform", sum_r, 'h80);
    chk("sum_g_uniform", sum_g, 'h100);
    chk("sum_b_uniform", sum_b, 'h180);
`endif

    repeat (10) tick();
    chk("pending_writes", exp_wr.size(), 0);
    chk("pending_reads", exp_rd.size(), 0);
    chk("pending_frames", exp_fr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
